// File: rtl/dice_match_tracker.sv
// Snapshot-and-scan dice comparator: latches N_DICE die values on sample, compares one die
// per clock against the target or die 0, then reports match, count, streak and a sticky win.
module dice_match_tracker #(
    parameter int WIDTH      = 4,
    parameter int N_DICE     = 2,
    parameter int THRESH     = 2,
    parameter int STREAK_W   = 4,
    parameter int WIN_STREAK = 3,
    localparam int CW        = $clog2(N_DICE + 1)
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [N_DICE*WIDTH-1:0]   dice,
    input  logic [WIDTH-1:0]          target,
    input  logic [1:0]                mode,
    input  logic                      sample,
    input  logic                      clr_streak,
    output logic                      busy,
    output logic                      result_valid,
    output logic                      match,
    output logic [CW-1:0]             match_count,
    output logic [STREAK_W-1:0]       streak,
    output logic                      win
);

    // state | meaning
    // IDLE  | waiting for sample; results held
    // SCAN  | comparing snapshot die[idx] against the reference, one per clock
    // DONE  | registering match/count, pulsing result_valid, updating streak/win
    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] SCAN = 2'd1;
    localparam logic [1:0] DONE = 2'd2;

    localparam int IW = (N_DICE > 1) ? $clog2(N_DICE) : 1;
    localparam logic [IW-1:0]       IDX_LAST   = IW'(N_DICE - 1);
    localparam logic [CW-1:0]       N_CW       = CW'(N_DICE);
    localparam logic [CW-1:0]       THRESH_CW  = CW'(THRESH);
    localparam logic [STREAK_W-1:0] STREAK_MAX = {STREAK_W{1'b1}};
    localparam logic [STREAK_W-1:0] WIN_SW     = STREAK_W'(WIN_STREAK);

    logic [1:0]              state_q, state_d;
    logic [N_DICE*WIDTH-1:0] snap_dice_q, snap_dice_d;
    logic [WIDTH-1:0]        snap_target_q, snap_target_d;
    logic [1:0]              snap_mode_q, snap_mode_d;
    logic [IW-1:0]           idx_q, idx_d;
    logic [CW-1:0]           cnt_q, cnt_d;
    logic                    busy_q, busy_d;
    logic                    rv_q, rv_d;
    logic                    match_q, match_d;
    logic [CW-1:0]           mc_q, mc_d;
    logic [STREAK_W-1:0]     streak_q, streak_d;
    logic                    win_q, win_d;

    logic [WIDTH-1:0] die_cur;
    logic [WIDTH-1:0] ref_val;
    logic             match_w;

    assign die_cur = snap_dice_q[idx_q*WIDTH +: WIDTH];
    assign ref_val = (snap_mode_q == 2'b10) ? snap_dice_q[WIDTH-1:0] : snap_target_q;

    always_comb begin
        case (snap_mode_q)
            2'b00:   match_w = (cnt_q == N_CW);
            2'b01:   match_w = (cnt_q != '0);
            2'b10:   match_w = (cnt_q == N_CW);
            default: match_w = (cnt_q >= THRESH_CW);
        endcase
    end

    always_comb begin
        state_d       = state_q;
        snap_dice_d   = snap_dice_q;
        snap_target_d = snap_target_q;
        snap_mode_d   = snap_mode_q;
        idx_d         = idx_q;
        cnt_d         = cnt_q;
        rv_d          = 1'b0;
        match_d       = match_q;
        mc_d          = mc_q;
        streak_d      = streak_q;
        win_d         = win_q;

        case (state_q)
            IDLE: begin
                if (sample) begin
                    snap_dice_d   = dice;
                    snap_target_d = target;
                    snap_mode_d   = mode;
                    idx_d         = '0;
                    cnt_d         = '0;
                    state_d       = SCAN;
                end
            end
            SCAN: begin
                if (die_cur == ref_val) cnt_d = cnt_q + CW'(1);
                if (idx_q == IDX_LAST) begin
                    state_d = DONE;
                end else begin
                    idx_d = idx_q + IW'(1);
                end
            end
            DONE: begin
                mc_d    = cnt_q;
                match_d = match_w;
                rv_d    = 1'b1;
                if (match_w) begin
                    streak_d = (streak_q == STREAK_MAX) ? STREAK_MAX : streak_q + STREAK_W'(1);
                end else begin
                    streak_d = '0;
                end
                if (streak_d >= WIN_SW) win_d = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase

        // Clearing wins over a same-cycle DONE update; match/count still land.
        if (clr_streak) begin
            streak_d = '0;
            win_d    = 1'b0;
        end

        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q       <= IDLE;
            snap_dice_q   <= '0;
            snap_target_q <= '0;
            snap_mode_q   <= '0;
            idx_q         <= '0;
            cnt_q         <= '0;
            busy_q        <= 1'b0;
            rv_q          <= 1'b0;
            match_q       <= 1'b0;
            mc_q          <= '0;
            streak_q      <= '0;
            win_q         <= 1'b0;
        end else begin
            state_q       <= state_d;
            snap_dice_q   <= snap_dice_d;
            snap_target_q <= snap_target_d;
            snap_mode_q   <= snap_mode_d;
            idx_q         <= idx_d;
            cnt_q         <= cnt_d;
            busy_q        <= busy_d;
            rv_q          <= rv_d;
            match_q       <= match_d;
            mc_q          <= mc_d;
            streak_q      <= streak_d;
            win_q         <= win_d;
        end
    end

    assign busy         = busy_q;
    assign result_valid = rv_q;
    assign match        = match_q;
    assign match_count  = mc_q;
    assign streak       = streak_q;
    assign win          = win_q;

endmodule

// File: tb/tb_dice_match_tracker.sv
// Bench for dice_match_tracker (N_DICE=2, WIDTH=4, STREAK_W=2, WIN_STREAK=3): vector table,
// hand-written corner sequences and randomized scans against a rule-level reference model.
module tb_dice_match_tracker;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] dice;
    logic [3:0] target;
    logic [1:0] mode;
    logic       sample;
    logic       clr_streak;
    logic       busy, result_valid, match, win;
    logic [1:0] match_count;
    logic [1:0] streak;

    int checks   = 0;
    int failures = 0;
    int m_streak = 0;
    int m_win    = 0;

    dice_match_tracker #(
        .WIDTH(4), .N_DICE(2), .THRESH(2), .STREAK_W(2), .WIN_STREAK(3)
    ) dut (
        .clk(clk), .rst(rst), .dice(dice), .target(target), .mode(mode),
        .sample(sample), .clr_streak(clr_streak), .busy(busy),
        .result_valid(result_valid), .match(match), .match_count(match_count),
        .streak(streak), .win(win)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] d;
        logic [3:0] t;
        logic [1:0] m;
        logic       em;
        int         ec;
    } vec_t;

    vec_t vecs[8];

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference model: count dice equal to the reference, apply the mode rule.
    function automatic int ref_count(input logic [7:0] d, input logic [3:0] t, input logic [1:0] m);
        int c = 0;
        logic [3:0] r;
        logic [3:0] die [2];
        die[0] = d[3:0];
        die[1] = d[7:4];
        r = (m == 2'b10) ? die[0] : t;
        for (int i = 0; i < 2; i++) if (die[i] == r) c++;
        return c;
    endfunction

    function automatic logic ref_match(input int c, input logic [1:0] m);
        case (m)
            2'b00:   return c == 2;
            2'b01:   return c >= 1;
            2'b10:   return c == 2;
            default: return c >= 2;
        endcase
    endfunction

    task automatic model_result(input logic mt);
        if (mt) m_streak = (m_streak + 1 > 3) ? 3 : m_streak + 1;
        else    m_streak = 0;
        if (m_streak >= 3) m_win = 1;
    endtask

    task automatic start_scan(input logic [7:0] d, input logic [3:0] t, input logic [1:0] m);
        dice = d; target = t; mode = m; sample = 1'b1;
        tick();
        sample = 1'b0;
    endtask

    task automatic wait_result(input string nm, input logic em, input int ec);
        int  lat = 0;
        bit  got = 0;
        while (!got && lat < 10) begin
            tick();
            lat++;
            if (result_valid) got = 1;
        end
        chk({nm, " latency"}, lat, 3);
        if (got) begin
            chk({nm, " match"}, match, em);
            chk({nm, " count"}, match_count, ec);
            model_result(em);
            chk({nm, " streak"}, streak, m_streak);
            chk({nm, " win"}, win, m_win);
            tick();
            chk({nm, " rv pulse"}, result_valid, 0);
            chk({nm, " busy end"}, busy, 0);
        end
    endtask

    task automatic scan(input string nm, input logic [7:0] d, input logic [3:0] t,
                        input logic [1:0] m, input logic em, input int ec);
        start_scan(d, t, m);
        chk({nm, " busy"}, busy, 1);
        wait_result(nm, em, ec);
    endtask

    initial begin
        vecs[0] = '{8'h55, 4'd5, 2'b00, 1'b1, 2};
        vecs[1] = '{8'h53, 4'd5, 2'b00, 1'b0, 1};
        vecs[2] = '{8'h36, 4'd6, 2'b01, 1'b1, 1};
        vecs[3] = '{8'h22, 4'd7, 2'b10, 1'b1, 2};
        vecs[4] = '{8'h24, 4'd0, 2'b10, 1'b0, 1};
        vecs[5] = '{8'h99, 4'd9, 2'b11, 1'b1, 2};
        vecs[6] = '{8'h91, 4'd9, 2'b11, 1'b0, 1};
        vecs[7] = '{8'h12, 4'd7, 2'b01, 1'b0, 0};

        rst = 1'b0; dice = '0; target = '0; mode = '0; sample = 1'b0; clr_streak = 1'b0;
        tick(); tick();
        chk("reset busy", busy, 0);
        chk("reset rv", result_valid, 0);
        chk("reset match", match, 0);
        chk("reset count", match_count, 0);
        chk("reset streak", streak, 0);
        chk("reset win", win, 0);
        rst = 1'b1;
        tick();

        for (int i = 0; i < 8; i++) scan($sformatf("vec%0d", i), vecs[i].d, vecs[i].t,
                                         vecs[i].m, vecs[i].em, vecs[i].ec);

        // Build a streak, then reset mid-scan.
        scan("pre-rst", 8'h77, 4'd7, 2'b00, 1'b1, 2);
        begin
            int rv_seen = 0;
            start_scan(8'h55, 4'd5, 2'b00);
            tick();
            rst = 1'b0;
            tick();
            if (result_valid) rv_seen++;
            tick();
            if (result_valid) rv_seen++;
            chk("rst-abort busy", busy, 0);
            chk("rst-abort match", match, 0);
            chk("rst-abort count", match_count, 0);
            chk("rst-abort streak", streak, 0);
            chk("rst-abort win", win, 0);
            rst = 1'b1;
            m_streak = 0; m_win = 0;
            for (int i = 0; i < 6; i++) begin
                tick();
                if (result_valid) rv_seen++;
            end
            chk("rst-abort no rv", rv_seen, 0);
            chk("rst-abort busy after", busy, 0);
        end

        // Streak, win, saturation, miss and clear.
        for (int i = 0; i < 5; i++) scan($sformatf("streak%0d", i), 8'h44, 4'd4, 2'b01, 1'b1, 2);
        chk("saturated streak", streak, 3);
        scan("miss", 8'h12, 4'd9, 2'b00, 1'b0, 0);
        chk("win sticky", win, 1);
        clr_streak = 1'b1;
        tick();
        clr_streak = 1'b0;
        m_streak = 0; m_win = 0;
        chk("clr win", win, 0);
        chk("clr streak", streak, 0);

        // sample during SCAN is ignored.
        begin
            int rv_seen = 0;
            logic mlast = 1'b0;
            start_scan(8'h55, 4'd5, 2'b00);
            dice = 8'h12; sample = 1'b1;
            tick();
            sample = 1'b0;
            for (int i = 0; i < 8; i++) begin
                tick();
                if (result_valid) begin rv_seen++; mlast = match; end
            end
            chk("ignore-sample rv count", rv_seen, 1);
            chk("ignore-sample match", mlast, 1);
            model_result(1'b1);
            chk("ignore-sample streak", streak, m_streak);
        end

        // Inputs changing after the sample edge do not affect the scan.
        start_scan(8'h33, 4'd3, 2'b00);
        dice = 8'h10; target = 4'd9; mode = 2'b01;
        wait_result("midscan", 1'b1, 2);

        // clr_streak in the DONE cycle of a match.
        start_scan(8'h66, 4'd6, 2'b00);
        tick();
        tick();
        clr_streak = 1'b1;
        tick();
        clr_streak = 1'b0;
        chk("clr-done rv", result_valid, 1);
        chk("clr-done match", match, 1);
        chk("clr-done count", match_count, 2);
        chk("clr-done streak", streak, 0);
        chk("clr-done win", win, 0);
        m_streak = 0; m_win = 0;
        tick();

        for (int n = 0; n < 60; n++) begin
            logic [7:0] d;
            logic [3:0] t;
            logic [1:0] m;
            int c;
            if ($urandom_range(0, 7) == 0) begin
                clr_streak = 1'b1;
                tick();
                clr_streak = 1'b0;
                m_streak = 0; m_win = 0;
            end
            d = {4'($urandom_range(0, 3)), 4'($urandom_range(0, 3))};
            t = 4'($urandom_range(0, 3));
            m = 2'($urandom_range(0, 3));
            c = ref_count(d, t, m);
            scan($sformatf("rand%0d", n), d, t, m, ref_match(c, m), c);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
